// File: rtl/alu_hs.sv
// alu_hs: parametrised ALU with valid/ready handshakes on input and output.
//
// Single-cycle ops (ADD, OR, AND, SUB, XOR, NOT, SLL, SRL, SRA, SLT, PASS and
// illegal opcodes) register their result at the accept edge. MUL is an
// iterative shift-add unit that processes one multiplier bit per cycle and
// loads its result after WIDTH cycles in BUSY.
//
// Handshake rules: a transfer happens on a rising clock edge where
// valid && ready. The input side is ready only in IDLE. The output side holds
// out/flags stable in DONE until out_ready is seen, then returns to IDLE.
// Operations never overlap, and in_valid while in_ready=0 is ignored.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   op/operands presented
//   in_ready   block can accept an operation (IDLE)
//   op         opcode (0..11 legal, 12..15 illegal)
//   input_a    operand A
//   input_b    operand B (low $clog2(WIDTH) bits are the shift amount)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out        result
//   flags      {illegal, overflow, carry, negative, zero}
//   dbg_state  current FSM state (IDLE=0, BUSY=1, DONE=2)
module alu_hs #(
  parameter int WIDTH      = 16,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [4:0]       flags,
  output logic [1:0]       dbg_state
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               accept;
  logic               is_mul;
  logic               mul_last;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ill;
  logic [4:0]         alu_flags;
  logic [4:0]         mul_flags;

  // Multiplier: multiplicand shifts left, multiplier shifts right, one bit
  // per BUSY cycle; the accumulator keeps the full 2*WIDTH product so the
  // overflow flag can look at the upper half.
  logic [2*WIDTH-1:0] mul_a_q;
  logic [2*WIDTH-1:0] mul_acc_q;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH-1:0]   mul_b_q;
  logic [SW-1:0]      cnt_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign dbg_state = state_q;

  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_ENABLE && (op == OP_MUL);
  assign add_ext  = {1'b0, input_a} + {1'b0, input_b};
  // Top bit of the extended difference is the unsigned borrow.
  assign sub_ext  = {1'b0, input_a} - {1'b0, input_b};
  assign sh       = input_b[SW-1:0];
  assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
  assign mul_last  = (cnt_q == SW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                  (add_ext[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_OR:   alu_res = input_a | input_b;
      OP_AND:  alu_res = input_a & input_b;
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                  (sub_ext[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_XOR:  alu_res = input_a ^ input_b;
      OP_NOT:  alu_res = ~input_a;
      OP_SLL:  alu_res = input_a << sh;
      OP_SRL:  alu_res = input_a >> sh;
      OP_SRA:  alu_res = $signed(input_a) >>> sh;
      // With the multiplier present this result is unused (MUL goes to BUSY).
      OP_MUL:  alu_ill = !MUL_ENABLE;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
      OP_PASS: alu_res = input_b;
      default: alu_ill = 1'b1;
    endcase
  end

  // Illegal ops leave alu_res at zero, so zero=1 and negative=0 fall out.
  assign alu_flags = {alu_ill, alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
  assign mul_flags = {1'b0, (mul_acc_d[2*WIDTH-1:WIDTH] != '0), 1'b0,
                      mul_acc_d[WIDTH-1], (mul_acc_d[WIDTH-1:0] == '0)};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (mul_last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out       <= '0;
      flags     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_acc_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        if (is_mul) begin
          mul_a_q   <= {{WIDTH{1'b0}}, input_a};
          mul_b_q   <= input_b;
          mul_acc_q <= '0;
          cnt_q     <= '0;
        end else begin
          out   <= alu_res;
          flags <= alu_flags;
        end
      end
      if (state_q == S_BUSY) begin
        mul_acc_q <= mul_acc_d;
        mul_a_q   <= mul_a_q << 1;
        mul_b_q   <= mul_b_q >> 1;
        cnt_q     <= cnt_q + 1'b1;
        // Last step folds its partial product straight into the result.
        if (mul_last) begin
          out   <= mul_acc_d[WIDTH-1:0];
          flags <= mul_flags;
        end
      end
    end
  end

endmodule
